// File: rtl/lamp_level_ctrl.sv
// lamp_level_ctrl: keeps a lamp target level (manual buttons, or motion + darkness in auto mode)
// and ramps active_lights toward it one lamp per RAMP_DIV cycles.
module lamp_level_ctrl #(
    parameter int RAMP_DIV     = 4,
    parameter int AUTO_LEVEL   = 10,
    parameter int IDLE_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mode_manual,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       motion,
    input  logic       dark,
    output logic [3:0] active_lights,
    output logic       ramping,
    output logic       occupied
);
    localparam int RW = $clog2(RAMP_DIV);
    localparam int IW = $clog2(IDLE_TIMEOUT);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [3:0]    AUTO_TGT  = 4'(AUTO_LEVEL);

    typedef enum logic {STEADY, RAMP} state_t;

    state_t        state, state_nx;
    logic [3:0]    target, target_nx, lights_nx, step_lights, auto_tgt;
    logic [RW-1:0] ramp_cnt, ramp_cnt_nx;
    logic [IW-1:0] idle_cnt, idle_cnt_nx;
    logic          occupied_nx;

    assign auto_tgt = dark ? AUTO_TGT : 4'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= STEADY;
            target        <= '0;
            active_lights <= '0;
            ramp_cnt      <= '0;
            idle_cnt      <= '0;
            occupied      <= 1'b0;
            ramping       <= 1'b0;
        end else begin
            state         <= state_nx;
            target        <= target_nx;
            active_lights <= lights_nx;
            ramp_cnt      <= ramp_cnt_nx;
            idle_cnt      <= idle_cnt_nx;
            occupied      <= occupied_nx;
            ramping       <= state_nx == RAMP;
        end
    end

    always_comb begin
        target_nx   = target;
        occupied_nx = occupied;
        idle_cnt_nx = idle_cnt;
        if (mode_manual) begin
            occupied_nx = 1'b0;
            idle_cnt_nx = '0;
            if (btn_up && !btn_down && target != 4'd15)
                target_nx = target + 4'd1;
            else if (btn_down && !btn_up && target != 4'd0)
                target_nx = target - 4'd1;
        end else if (motion) begin
            occupied_nx = 1'b1;
            idle_cnt_nx = '0;
            target_nx   = auto_tgt;
        end else if (occupied) begin
            if (idle_cnt == IDLE_LAST) begin
                occupied_nx = 1'b0;
                idle_cnt_nx = '0;
                target_nx   = 4'd0;
            end else begin
                idle_cnt_nx = idle_cnt + 1'b1;
                target_nx   = auto_tgt;
            end
        end else begin
            target_nx = 4'd0;
        end
    end

    // The ramp follows the registered target, so a new target is seen one edge after it is set.
    always_comb begin
        state_nx    = state;
        ramp_cnt_nx = ramp_cnt;
        lights_nx   = active_lights;
        step_lights = (target > active_lights) ? active_lights + 4'd1 : active_lights - 4'd1;
        if (state == STEADY) begin
            if (target != active_lights) begin
                state_nx    = RAMP;
                ramp_cnt_nx = '0;
            end
        end else if (target == active_lights) begin
            state_nx    = STEADY;
            ramp_cnt_nx = '0;
        end else if (ramp_cnt == RAMP_LAST) begin
            lights_nx   = step_lights;
            ramp_cnt_nx = '0;
            state_nx    = (step_lights == target) ? STEADY : RAMP;
        end else begin
            ramp_cnt_nx = ramp_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_lamp_level_ctrl.sv
// tb_lamp_level_ctrl: directed scenarios plus random stimulus, checked every cycle against
// an arithmetic model of target level and stepping schedule.
module tb_lamp_level_ctrl;
    localparam int RAMP_DIV = 4, AUTO_LEVEL = 10, IDLE_TIMEOUT = 32;

    logic clk = 0, reset_n = 0, mode_manual = 1, btn_up = 0, btn_down = 0, motion = 0, dark = 0;
    logic [3:0] active_lights;
    logic ramping, occupied;
    int n_checks = 0, n_pass = 0;

    lamp_level_ctrl #(.RAMP_DIV(RAMP_DIV), .AUTO_LEVEL(AUTO_LEVEL), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .mode_manual(mode_manual), .btn_up(btn_up),
        .btn_down(btn_down), .motion(motion), .dark(dark), .active_lights(active_lights),
        .ramping(ramping), .occupied(occupied)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tgt, al, idle, since;
        bit occ, ramp;
    } model_t;

    model_t m;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // since counts edges spent ramping; a step is due every RAMP_DIV-th of them.
    function automatic model_t next(model_t s, bit man, bit up, bit dn, bit mot, bit dk);
        model_t n = s;
        int lvl = dk ? AUTO_LEVEL : 0;
        if (man) begin
            n.occ = 0;
            n.idle = 0;
            if (up && !dn) n.tgt = (s.tgt < 15) ? s.tgt + 1 : 15;
            if (dn && !up) n.tgt = (s.tgt > 0) ? s.tgt - 1 : 0;
        end else if (mot) begin
            n.occ = 1;
            n.idle = 0;
            n.tgt = lvl;
        end else if (s.occ && s.idle == IDLE_TIMEOUT - 1) begin
            n.occ = 0;
            n.idle = 0;
            n.tgt = 0;
        end else if (s.occ) begin
            n.idle = s.idle + 1;
            n.tgt = lvl;
        end else n.tgt = 0;
        if (!s.ramp) begin
            if (s.tgt != s.al) begin
                n.ramp = 1;
                n.since = 0;
            end
        end else if (s.tgt == s.al) n.ramp = 0;
        else begin
            n.since = s.since + 1;
            if (n.since % RAMP_DIV == 0) begin
                n.al = s.al + ((s.tgt > s.al) ? 1 : -1);
                n.ramp = (n.al != s.tgt);
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n)
        if (!reset_n) m <= '{default: 0};
        else m <= next(m, mode_manual, btn_up, btn_down, motion, dark);

    always @(negedge clk)
        if (reset_n) begin
            chk("model_lights", int'(active_lights), m.al);
            chk("model_ramping", int'(ramping), int'(m.ramp));
            chk("model_occupied", int'(occupied), int'(m.occ));
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input bit up, input bit dn);
        btn_up = up;
        btn_down = dn;
        tick();
        btn_up = 0;
        btn_down = 0;
    endtask

    task automatic wait_al(input string name, input int v, input int lim);
        for (int i = 0; i < lim && !(int'(active_lights) == v && !ramping); i++) tick();
        chk(name, int'(active_lights), v);
        chk({name, "_steady"}, int'(ramping), 0);
    endtask

    initial begin
        int mx;
        #12;
        chk("reset_lights", int'(active_lights), 0);
        chk("reset_ramping", int'(ramping), 0);
        chk("reset_occupied", int'(occupied), 0);
        reset_n = 1;
        ticks(2);

        btn_up = 1;
        tick();
        chk("up_e0_ramping", int'(ramping), 0);
        tick();
        chk("up_e1_ramping", int'(ramping), 1);
        tick();
        btn_up = 0;
        ticks(2);
        chk("up_e4", int'(active_lights), 0);
        tick();
        chk("up_e5", int'(active_lights), 1);
        ticks(3);
        chk("up_e8", int'(active_lights), 1);
        tick();
        chk("up_e9", int'(active_lights), 2);
        ticks(4);
        chk("up_e13", int'(active_lights), 3);
        chk("up_e13_ramping", int'(ramping), 0);

        for (int i = 0; i < 20; i++) press(1, 0);
        wait_al("sat_top", 15, 100);
        press(1, 0);
        ticks(10);
        chk("sat_top_hold", int'(active_lights), 15);
        chk("sat_top_ramping", int'(ramping), 0);
        for (int i = 0; i < 20; i++) press(0, 1);
        wait_al("sat_bottom", 0, 100);
        press(0, 1);
        ticks(10);
        chk("sat_bottom_hold", int'(active_lights), 0);
        for (int i = 0; i < 3; i++) press(1, 0);
        wait_al("level3", 3, 30);
        press(1, 1);
        ticks(10);
        chk("both_buttons", int'(active_lights), 3);
        chk("both_buttons_ramping", int'(ramping), 0);

        for (int i = 0; i < 5; i++) press(1, 0);
        for (int i = 0; i < 60 && active_lights != 4'd6; i++) tick();
        chk("pre_reset_level", int'(active_lights), 6);
        chk("pre_reset_ramping", int'(ramping), 1);
        #2 reset_n = 0;
        #1;
        chk("async_reset_lights", int'(active_lights), 0);
        chk("async_reset_ramping", int'(ramping), 0);
        chk("async_reset_occupied", int'(occupied), 0);
        @(posedge clk);
        #1 reset_n = 1;
        ticks(10);
        chk("post_reset_lights", int'(active_lights), 0);
        chk("post_reset_ramping", int'(ramping), 0);

        mode_manual = 0;
        dark = 1;
        for (int e = 0; e <= 130; e++) begin
            motion = (e < 50);
            tick();
            if (e == 40) chk("auto_e40", int'(active_lights), 9);
            if (e == 41) chk("auto_e41", int'(active_lights), 10);
            if (e == 80) chk("auto_e80_occ", int'(occupied), 1);
            if (e == 81) chk("auto_e81_occ", int'(occupied), 0);
            if (e == 85) chk("auto_e85", int'(active_lights), 10);
            if (e == 86) chk("auto_e86", int'(active_lights), 9);
            if (e == 121) chk("auto_e121", int'(active_lights), 1);
            if (e == 122) begin
                chk("auto_e122", int'(active_lights), 0);
                chk("auto_e122_ramping", int'(ramping), 0);
            end
        end

        motion = 1;
        for (int i = 0; i < 40 && active_lights != 4'd4; i++) tick();
        chk("dark_level4", int'(active_lights), 4);
        dark = 0;
        mx = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (int'(active_lights) > mx) mx = int'(active_lights);
        end
        chk("dark_drop_max", mx, 4);
        wait_al("dark_drop_zero", 0, 40);

        motion = 0;
        mode_manual = 1;
        for (int i = 0; i < 7; i++) press(1, 0);
        wait_al("manual7", 7, 60);
        chk("manual7_occupied", int'(occupied), 0);
        mode_manual = 0;
        wait_al("auto_off", 0, 60);
        mode_manual = 1;
        ticks(3);
        chk("back_manual_hold", int'(active_lights), 0);
        press(1, 0);
        wait_al("back_manual_up", 1, 20);

        dark = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 200 == 0) mode_manual = ~mode_manual;
            if ($urandom % 40 == 0) motion = ~motion;
            if ($urandom % 60 == 0) dark = ~dark;
            btn_up = ($urandom % 6 == 0);
            btn_down = ($urandom % 7 == 0);
            tick();
            if ($urandom % 1000 == 0) begin
                #2 reset_n = 0;
                #1 reset_n = 1;
            end
        end
        btn_up = 0;
        btn_down = 0;
        ticks(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
